nes_controller_reader: RTL and testbench
========================================

Name: nes_controller_reader

Overview:
- Upstream input stage feeding the Pong game core. Polls two NES controllers over the standard latch/clock/serial-data protocol and presents debounced-by-frame, active-high button vectors to the game logic.
- One read is issued per `poll` strobe, normally the VGA frame strobe at about 60 Hz.
- Both controllers share timing. Each controller has its own latch/clock pins because they sit on separate bidirectional pins at the top level.

Parameters:
- LATCH_CYCLES, 302, width of the latch pulse in clk cycles (12 us at 25.175 MHz); minimum 4.
- HALF_CYCLES, 151, length of each nes_clk low or high phase in clk cycles (6 us); minimum 4.
- CNT_W, 9, timing counter width; must satisfy 2^CNT_W > max(LATCH_CYCLES, HALF_CYCLES).

Ports:
- clk  input  1  system clock, 25.175 MHz.
- reset  input  1  synchronous, active-high reset.
- poll  input  1  single-cycle request to start a read frame.
- nes_data  input  2  serial data from controller 1 (bit 0) and controller 2 (bit 1); asynchronous, active-low (0 = pressed).
- nes_latch  output  2  latch pulse to each controller; both bits are identical.
- nes_clk  output  2  shift clock to each controller; both bits are identical.
- buttons_p1  output  8  controller 1 buttons, active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- buttons_p2  output  8  controller 2 buttons, same bit order.
- valid  output  1  one-cycle pulse when buttons_p1/p2 are updated.
- busy  output  1  high while a read frame is in progress.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: nes_latch=00, nes_clk=11 (idle high), buttons_p1=buttons_p2=0x00, valid=0, busy=0, FSM=IDLE, shift registers cleared.
- Reset asserted mid-frame aborts the frame immediately. Outputs return to their reset values on the next edge, and no valid pulse is produced.
- Input synchronisation: nes_data passes through a 2-flop synchroniser per bit. All sampling uses the synchronised value.
- FSM states and transitions:
  - IDLE: poll=1 -> LATCH, counter=0, busy=1.
  - LATCH: nes_latch=11 for exactly LATCH_CYCLES cycles, then -> LOW with bit index=0.
  - LOW: nes_clk=00 for HALF_CYCLES cycles. On the last LOW cycle, shift in ~sync_data[n] at position index for each controller. Then -> HIGH.
  - HIGH: nes_clk=11 for HALF_CYCLES cycles. If index=7 -> DONE; else index+1 and -> LOW. The controller shifts the next bit on this rising edge.
  - DONE: one cycle. buttons_p1/p2 load both shift registers in the same edge (atomic update), valid=1, busy=0 on exit -> IDLE.
- Cycle timing: a poll sampled at edge k gives:
  - nes_latch high for cycles k+1..k+LATCH_CYCLES;
  - 8 full nes_clk low/high pulses;
  - valid high at cycle k+LATCH_CYCLES+16*HALF_CYCLES+1 (k+2719 with defaults);
  - busy high from k+1 through the valid cycle.
- poll while busy is ignored; it is not queued. A poll in the DONE cycle is also ignored. A poll in the first IDLE cycle after DONE is accepted.
- buttons_p1/p2 hold their values between valid pulses. They never show partial frames.
- Disconnected controller: the pad pull-up reads 1 on every bit, so its vector is 0x00. The other controller is unaffected.
- Counter never exceeds max(LATCH_CYCLES, HALF_CYCLES)-1; wraps to 0 at each phase transition.

Test Plan:
- Reset: hold reset 3 cycles mid-frame -> next edge nes_latch=00, nes_clk=11, buttons=0x00, busy=0; no valid pulse appears afterwards.
- Single read: controller models (latched shift register, shift on nes_clk rising edge) hold p1=A+Up (data 0b11101110, LSB first), p2=Start+Right. Pulse poll -> valid at k+2719 with buttons_p1=0x11, buttons_p2=0x88. Latch width 302 cycles; exactly 8 nes_clk rising edges.
- Poll while busy: pulse poll at k and again at k+1000 -> only one frame; exactly one valid pulse; nes_latch rises only once.
- Back-to-back: poll held high continuously -> frames repeat with one IDLE cycle between the valid pulse and the next latch rise. Changing model data between frames updates the buttons only at valid.
- Disconnected: nes_data[1] tied 1, p1 all pressed (data all 0) -> buttons_p1=0xFF, buttons_p2=0x00.
- Glitch tolerance: toggle nes_data asynchronously except during a 4-cycle window before each LOW-phase end -> the sampled result matches the stable values in those windows.

Source files
------------

// File: rtl/nes_controller_reader.sv
// Polls two NES pads once per poll strobe and publishes active-high button
// vectors atomically, with a valid pulse, at the end of each read frame.
module nes_controller_reader #(
  parameter int LATCH_CYCLES = 302,
  parameter int HALF_CYCLES  = 151,
  parameter int CNT_W        = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll,
  input  logic [1:0] nes_data,
  output logic [1:0] nes_latch,
  output logic [1:0] nes_clk,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       sr_p1, sr_p2;
  logic [1:0]       data_sync_p0, data_sync_p1;
  logic             latch_end, half_end;

  assign latch_end = (cnt == CNT_W'(LATCH_CYCLES - 1));
  assign half_end  = (cnt == CNT_W'(HALF_CYCLES - 1));

  // Stage p0/p1: two-flop synchroniser for the asynchronous pad data
  always_ff @(posedge clk) begin
    data_sync_p0 <= nes_data;
    data_sync_p1 <= data_sync_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (poll) state_nxt = LATCH;
      LATCH:   if (latch_end) state_nxt = LOW;
      LOW:     if (half_end) state_nxt = HIGH;
      HIGH:    if (half_end) state_nxt = (idx == 3'd7) ? DONE : LOW;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    nes_latch = (state == LATCH) ? 2'b11 : 2'b00;
    nes_clk   = (state == LOW)   ? 2'b00 : 2'b11;
    valid     = (state == DONE);
    busy      = (state != IDLE);
  end

  // Phase counter restarts on every state change so each phase is timed from zero
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || state_nxt != state) cnt <= '0;
    else                                              cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || state == LATCH)   idx <= 3'd0;
    else if (state == HIGH && half_end) idx <= idx + 3'd1;
  end

  // Sample at the very end of the low phase, when the pad output has long settled
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_p1 <= 8'h00;
      sr_p2 <= 8'h00;
    end else if (state == LOW && half_end) begin
      sr_p1[idx] <= ~data_sync_p1[0];
      sr_p2[idx] <= ~data_sync_p1[1];
    end
  end

  // Both vectors change on the same edge that enters DONE, so they never mix frames
  always_ff @(posedge clk) begin
    if (reset) begin
      buttons_p1 <= 8'h00;
      buttons_p2 <= 8'h00;
    end else if (state == HIGH && half_end && idx == 3'd7) begin
      buttons_p1 <= sr_p1;
      buttons_p2 <= sr_p2;
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Scoreboard bench for nes_controller_reader with behavioural NES pad models.
module tb_nes_controller_reader;
  localparam int LATCH_CYCLES = 302;
  localparam int HALF_CYCLES  = 151;
  localparam int CNT_W        = 9;
  localparam int FRAME        = LATCH_CYCLES + 16 * HALF_CYCLES + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       poll = 1'b0;
  logic [1:0] nes_data;
  logic [1:0] nes_latch, nes_clk;
  logic [7:0] buttons_p1, buttons_p2;
  logic       valid, busy;

  nes_controller_reader #(
    .LATCH_CYCLES(LATCH_CYCLES),
    .HALF_CYCLES (HALF_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .poll      (poll),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .buttons_p1(buttons_p1),
    .buttons_p2(buttons_p2),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc + 1);
    end
  endtask

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    int         vcyc;
  } exp_t;
  exp_t sb[$];

  // Pad models: parallel load while latch is high, shift on nes_clk rising edge
  logic [7:0] pad [2];
  logic [7:0] sh  [2];
  logic [1:0] disc = 2'b00;
  logic [1:0] prev_nclk = 2'b11;
  bit         glitch_en = 1'b0;
  int         lc = -1;

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (nes_latch[n] === 1'b1) sh[n] = pad[n];
      else if (nes_clk[n] === 1'b1 && prev_nclk[n] === 1'b0) sh[n] = {1'b1, sh[n][7:1]};
    end
    prev_nclk = nes_clk;
    lc = (nes_clk[0] === 1'b0) ? lc + 1 : -1;
    for (int n = 0; n < 2; n++) begin
      logic raw;
      raw = disc[n] ? 1'b1 : sh[n][0];
      if (glitch_en && !(lc >= HALF_CYCLES - 4)) raw = raw ^ 1'($urandom_range(0, 1));
      nes_data[n] = raw;
    end
  end

  function automatic logic [7:0] ref_buttons(input int n);
    return disc[n] ? 8'h00 : ~pad[n];
  endfunction

  // Monitor: pops expectations on each valid pulse, tracks protocol timing
  bit         mon_en = 1'b0;
  logic       prev_latch = 1'b0, prev_clk = 1'b1;
  int         latch_rises = 0, valid_cnt = 0, lw = 0, nrise = 0;
  int         pair_err = 0, hold_err = 0, busy_err = 0;
  logic [7:0] last_p1 = 8'h00, last_p2 = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        last_p1 = 8'h00;
        last_p2 = 8'h00;
      end else begin
        logic exp_busy;
        exp_busy = (sb.size() > 0) && (cyc + 1 >= sb[0].vcyc - FRAME + 1);
        if (busy !== exp_busy) busy_err++;
        if (nes_latch !== {2{nes_latch[0]}} || nes_clk !== {2{nes_clk[0]}}) pair_err++;
        if (nes_latch[0] && !prev_latch) begin
          latch_rises++;
          lw = 0;
          nrise = 0;
        end
        if (nes_latch[0]) lw++;
        if (nes_clk[0] && !prev_clk) nrise++;
        if (valid) begin
          valid_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid=1, expected 0 (cycle %0d)", cyc + 1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("buttons_p1", buttons_p1, e.p1);
            check("buttons_p2", buttons_p2, e.p2);
            check("valid_cycle", cyc + 1, e.vcyc);
            check("latch_width", lw, LATCH_CYCLES);
            check("nes_clk_rises", nrise, 8);
            last_p1 = e.p1;
            last_p2 = e.p2;
          end
        end else if (buttons_p1 !== last_p1 || buttons_p2 !== last_p2) begin
          hold_err++;
        end
      end
      prev_latch = nes_latch[0];
      prev_clk   = nes_clk[0];
    end
  end

  task automatic start_frame();
    int k;
    @(posedge clk);
    #1;
    poll = 1'b1;
    k = cyc + 1;
    sb.push_back('{ref_buttons(0), ref_buttons(1), k + FRAME});
    @(posedge clk);
    #1;
    poll = 1'b0;
  endtask

  task automatic drain(input int bound);
    int t = 0;
    while (sb.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_in_time", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_valid(output int v);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!valid && t < FRAME + 50);
    if (!valid) check("valid_timeout", 0, 1);
    v = cyc + 1;
  endtask

  task automatic randomize_pads();
    pad[0] = 8'($urandom);
    pad[1] = 8'($urandom);
  endtask

  initial begin
    int r0, v0, vcyc;
    pad[0] = 8'hFF; pad[1] = 8'hFF;
    sh[0]  = 8'hFF; sh[1]  = 8'hFF;

    // Power-on reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_latch", nes_latch, 2'b00);
    check("rst_clk", nes_clk, 2'b11);
    check("rst_p1", buttons_p1, 8'h00);
    check("rst_p2", buttons_p2, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single read: p1 = A+Up, p2 = Start+Right
    pad[0] = 8'b1110_1110;
    pad[1] = 8'b0111_0111;
    start_frame();
    drain(FRAME + 100);

    // Reset mid-frame aborts without a valid pulse
    start_frame();
    repeat (1000) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_latch", nes_latch, 2'b00);
    check("midrst_clk", nes_clk, 2'b11);
    check("midrst_p1", buttons_p1, 8'h00);
    check("midrst_p2", buttons_p2, 8'h00);
    check("midrst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    v0 = valid_cnt;
    repeat (FRAME + 100) @(posedge clk);
    check("midrst_no_valid", valid_cnt - v0, 0);

    // Poll while busy is ignored
    r0 = latch_rises;
    v0 = valid_cnt;
    randomize_pads();
    start_frame();
    repeat (997) @(posedge clk);
    #1;
    poll = 1'b1;
    @(posedge clk);
    #1;
    poll = 1'b0;
    drain(FRAME + 100);
    repeat (50) @(posedge clk);
    check("busy_poll_latches", latch_rises - r0, 1);
    check("busy_poll_valids", valid_cnt - v0, 1);

    // Random single frames
    for (int i = 0; i < 4; i++) begin
      randomize_pads();
      start_frame();
      drain(FRAME + 100);
    end

    // Back-to-back with poll held high; one IDLE cycle between frames
    randomize_pads();
    @(posedge clk);
    #1;
    poll = 1'b1;
    sb.push_back('{ref_buttons(0), ref_buttons(1), cyc + 1 + FRAME});
    for (int i = 0; i < 3; i++) begin
      wait_valid(vcyc);
      if (i < 2) begin
        randomize_pads();
        sb.push_back('{ref_buttons(0), ref_buttons(1), vcyc + 1 + FRAME});
      end else begin
        poll = 1'b0;
      end
    end
    drain(FRAME + 100);

    // Disconnected controller 2, all buttons pressed on controller 1
    disc   = 2'b10;
    pad[0] = 8'h00;
    pad[1] = 8'h00;
    start_frame();
    drain(FRAME + 100);
    disc = 2'b00;

    // Glitchy data outside the sampling windows
    glitch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_pads();
      start_frame();
      drain(FRAME + 100);
    end
    glitch_en = 1'b0;
    repeat (20) @(posedge clk);

    check("latch_clk_pairs", pair_err, 0);
    check("button_hold", hold_err, 0);
    check("busy_track", busy_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish before cycle 90000");
    $fatal(1, "watchdog expired");
  end
endmodule
